// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the RV32I ALU operation decoder:
//   - alu_op_e      : 6-bit ALU operation encoding driven on ALUop_o
//   - OPC_*         : the major opcodes the decoder recognises
//   - F3_* / F7_*   : funct3 / funct7 field values
//   - issue_entry_t : one decoded entry as held in the issue buffer
//   - imm_i / imm_j : sign-extended immediate extraction helpers
// -----------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [5:0] {
    ALU_NONE = 6'd0,
    ALU_ADD  = 6'd1,
    ALU_SLL  = 6'd2,
    ALU_SLT  = 6'd3,
    ALU_SLTU = 6'd4,
    ALU_XOR  = 6'd5,
    ALU_SRL  = 6'd6,
    ALU_SRA  = 6'd7,
    ALU_OR   = 6'd8,
    ALU_AND  = 6'd9,
    ALU_SUB  = 6'd10,
    ALU_BEQ  = 6'd11,
    ALU_BNE  = 6'd12,
    ALU_BLT  = 6'd13,
    ALU_BGE  = 6'd14,
    ALU_BLTU = 6'd15,
    ALU_BGEU = 6'd16,
    ALU_JAL  = 6'd17
  } alu_op_e;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // funct3 for OP / OP-IMM
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // funct3 for BRANCH
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // funct7: base encoding and the alternate (SUB / SRA) encoding
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_op_e     alu_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd;
    logic        is_branch;
    logic        illegal;
  } issue_entry_t;

  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// -----------------------------------------------------------------------------
// alu_op_decode
// Purely combinational RV32I decode of one instruction into an issue entry.
// Ports:
//   instr_i    [31:0] : instruction word
//   pc_i       [31:0] : PC of the instruction (used for JAL link value)
//   rs1_data_i [31:0] : register-file read value for rs1
//   rs2_data_i [31:0] : register-file read value for rs2
//   entry_o           : decoded entry (ALU op, operands, rd, flags)
// Anything not recognised decodes to ALU_NONE with zero operands, rd=0 and
// illegal=1; the entry is still issued downstream.
// -----------------------------------------------------------------------------
module alu_op_decode (
  input  logic [31:0]           instr_i,
  input  logic [31:0]           pc_i,
  input  logic [31:0]           rs1_data_i,
  input  logic [31:0]           rs2_data_i,
  output alu_pkg::issue_entry_t entry_o
);

  import alu_pkg::*;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  alu_op_e     alu_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        is_branch;
  logic        illegal;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  // NOTE: every signal written here gets a default first, so no path through
  // the case statements can leave one unassigned and infer a latch.
  always_comb begin
    alu_op    = ALU_NONE;
    op_a      = '0;
    op_b      = '0;
    is_branch = 1'b0;

    case (opcode)
      OPC_OP: begin
        op_a = rs1_data_i;
        op_b = rs2_data_i;
        case (funct7)
          F7_BASE: begin
            case (funct3)
              F3_ADD_SUB: alu_op = ALU_ADD;
              F3_SLL:     alu_op = ALU_SLL;
              F3_SLT:     alu_op = ALU_SLT;
              F3_SLTU:    alu_op = ALU_SLTU;
              F3_XOR:     alu_op = ALU_XOR;
              F3_SRL_SRA: alu_op = ALU_SRL;
              F3_OR:      alu_op = ALU_OR;
              F3_AND:     alu_op = ALU_AND;
              default:    alu_op = ALU_NONE;
            endcase
          end
          F7_ALT: begin
            case (funct3)
              F3_ADD_SUB: alu_op = ALU_SUB;
              F3_SRL_SRA: alu_op = ALU_SRA;
              default:    alu_op = ALU_NONE;
            endcase
          end
          default: alu_op = ALU_NONE;
        endcase
      end

      OPC_OP_IMM: begin
        op_a = rs1_data_i;
        op_b = imm_i(instr_i);
        // Only the shift-immediates constrain the upper immediate bits: they
        // carry a 5-bit shamt, so instr[31:25] must be an exact funct7 value
        // (this also rejects instr[25]=1). For the rest it is just immediate.
        case (funct3)
          F3_ADD_SUB: alu_op = ALU_ADD;
          F3_SLT:     alu_op = ALU_SLT;
          F3_SLTU:    alu_op = ALU_SLTU;
          F3_XOR:     alu_op = ALU_XOR;
          F3_OR:      alu_op = ALU_OR;
          F3_AND:     alu_op = ALU_AND;
          F3_SLL:     alu_op = (funct7 == F7_BASE) ? ALU_SLL : ALU_NONE;
          F3_SRL_SRA: begin
            if (funct7 == F7_BASE)     alu_op = ALU_SRL;
            else if (funct7 == F7_ALT) alu_op = ALU_SRA;
            else                       alu_op = ALU_NONE;
          end
          default:    alu_op = ALU_NONE;
        endcase
      end

      OPC_BRANCH: begin
        op_a      = rs1_data_i;
        op_b      = rs2_data_i;
        is_branch = 1'b1;
        case (funct3)
          F3_BEQ:  alu_op = ALU_BEQ;
          F3_BNE:  alu_op = ALU_BNE;
          F3_BLT:  alu_op = ALU_BLT;
          F3_BGE:  alu_op = ALU_BGE;
          F3_BLTU: alu_op = ALU_BLTU;
          F3_BGEU: alu_op = ALU_BGEU;
          default: alu_op = ALU_NONE;
        endcase
      end

      OPC_JAL: begin
        alu_op = ALU_JAL;
        op_a   = pc_i + 32'd4;  // link value, wraps modulo 2^32
        op_b   = imm_j(instr_i);
      end

      default: alu_op = ALU_NONE;
    endcase

    illegal = (alu_op == ALU_NONE);
  end

  // Illegal entries carry nothing but the illegal flag; branches write no rd.
  always_comb begin
    entry_o           = '0;
    entry_o.illegal   = illegal;
    if (!illegal) begin
      entry_o.alu_op    = alu_op;
      entry_o.op_a      = op_a;
      entry_o.op_b      = op_b;
      entry_o.is_branch = is_branch;
      entry_o.rd        = is_branch ? 5'd0 : instr_i[11:7];
    end
  end

endmodule

// File: rtl/alu_op_decoder.sv
// -----------------------------------------------------------------------------
// alu_op_decoder
// Decodes RV32I ALU/branch/JAL instructions and queues the decoded entries in
// an in-order issue buffer of DEPTH entries (1..4).
// Ports:
//   clk_i, rst_ni        : clock (rising edge), async active-low reset
//   instr_valid_i/ready_o: instruction handshake (accept on valid && ready)
//   instr_i, pc_i        : instruction word and its PC
//   rs1_data_i/rs2_data_i: register read values, captured at accept time
//   issue_valid_o/ready_i: issue handshake (pop on valid && ready)
//   ALUop_o, operand_A_o, operand_B_o, rd_o, is_branch_o, illegal_o
//                        : head-of-buffer entry, all zero when empty
// An accepted instruction reaches the issue outputs one cycle later at the
// earliest; there is no combinational bypass around the buffer.
// -----------------------------------------------------------------------------
module alu_op_decoder #(
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  output logic        issue_valid_o,
  input  logic        issue_ready_i,
  output logic [5:0]  ALUop_o,
  output logic [31:0] operand_A_o,
  output logic [31:0] operand_B_o,
  output logic [4:0]  rd_o,
  output logic        is_branch_o,
  output logic        illegal_o
);

  import alu_pkg::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  issue_entry_t     dec_entry;
  issue_entry_t     head_entry;
  issue_entry_t     mem_q [DEPTH];
  issue_entry_t     mem_d [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             push;
  logic             pop;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  alu_op_decode u_decode (
    .instr_i    (instr_i),
    .pc_i       (pc_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .entry_o    (dec_entry)
  );

  // Accepting while full is allowed when the head leaves in the same cycle.
  assign issue_valid_o = (count_q != '0);
  assign instr_ready_o = (count_q < CNT_W'(DEPTH)) || issue_ready_i;
  assign push          = instr_valid_i && instr_ready_o;
  assign pop           = issue_valid_o && issue_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;

    if (push) begin
      mem_d[wr_ptr_q] = dec_entry;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the entry storage is deliberately not reset; an empty buffer masks
  // it at the outputs, so stale contents can never be observed.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign head_entry  = issue_valid_o ? mem_q[rd_ptr_q] : '0;

  assign ALUop_o     = head_entry.alu_op;
  assign operand_A_o = head_entry.op_a;
  assign operand_B_o = head_entry.op_b;
  assign rd_o        = head_entry.rd;
  assign is_branch_o = head_entry.is_branch;
  assign illegal_o   = head_entry.illegal;

endmodule

// File: doc/alu_op_decoder.md
ALU_OP_DECODER -- requirements
Module: alu_op_decoder

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the issue-buffer entry count (legal values 1..4).
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk_i and rst_ni.
REQ-003 SHALL have port clk_i, input, 1 bit: clock; all state samples on the rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port instr_valid_i, input, 1 bit: an instruction is offered.
REQ-006 SHALL have port instr_ready_o, output, 1 bit: the block can accept an instruction.
REQ-007 SHALL have port instr_i, input, 32 bits: RV32I instruction word.
REQ-008 SHALL have ports pc_i, rs1_data_i and rs2_data_i, input, 32 bits each: instruction PC and the two register-file read values.
REQ-009 SHALL have port issue_valid_o, output, 1 bit: the buffer head is valid.
REQ-010 SHALL have port issue_ready_i, input, 1 bit: the ALU stage consumes the head.
REQ-011 SHALL have port ALUop_o, output, 6 bits: ALU operation code.
REQ-012 SHALL have ports operand_A_o and operand_B_o, output, 32 bits each: ALU operands.
REQ-013 SHALL have ports rd_o (output, 5 bits: destination register), is_branch_o (output, 1 bit) and illegal_o (output, 1 bit).

Function
REQ-014 SHALL accept an instruction when instr_valid_i && instr_ready_o on a rising edge, and SHALL present it on the issue outputs exactly 1 cycle later when the buffer was empty.
REQ-015 SHALL decode into ALUop_o as follows: ADD/ADDI=1, SLL/SLLI=2, SLT/SLTI=3, SLTU/SLTIU=4, XOR/XORI=5, SRL/SRLI=6, SRA/SRAI=7, OR/ORI=8, AND/ANDI=9, SUB=10, BEQ=11, BNE=12, BLT=13, BGE=14, BLTU=15, BGEU=16, JAL=17.
REQ-016 SHALL select SUB versus ADD, and SRA versus SRL, using instr[30] for OP (0110011); for OP-IMM (0010011), instr[30] selects SRAI only.
REQ-017 SHALL drive operands as follows: OP and BRANCH: A=rs1_data_i, B=rs2_data_i; OP-IMM: A=rs1_data_i, B=sign-extended I-immediate; JAL: A=pc_i+4 (mod 2^32), B=sign-extended J-immediate.
REQ-018 SHALL decode any other opcode, an unused funct3/funct7 combination, or SLLI/SRLI/SRAI with instr[25]=1 as illegal: ALUop_o=0, operands 0, illegal_o=1, and the entry is still issued.
REQ-019 SHALL drive rd_o=instr[11:7] except for BRANCH or illegal instructions, where rd_o=0; is_branch_o=1 only for BRANCH.
REQ-020 SHALL capture the operands at accept time, so later changes to rs1_data_i, rs2_data_i or pc_i do not affect a buffered entry.
REQ-021 SHALL hold the buffer as an in-order FIFO with DEPTH entries and an occupancy count from 0 to DEPTH.
REQ-022 SHALL pop the head on issue_valid_o && issue_ready_i.
REQ-023 SHALL drive instr_ready_o = (count < DEPTH) || issue_ready_i, allowing push and pop together when full.
REQ-024 SHALL, on a simultaneous push and pop, leave count unchanged and advance the head.
REQ-025 SHALL, when count=0 and a push occurs, produce no combinational bypass: issue_valid_o asserts the next cycle.
REQ-026 SHALL let the read and write pointers wrap modulo DEPTH.
REQ-027 SHALL hold all issue outputs stable while issue_valid_o && !issue_ready_i.
REQ-028 SHALL drive all issue data outputs to 0 when count=0.

Reset
REQ-029 SHALL, while rst_ni=0, immediately set count=0 and both pointers=0, drive issue_valid_o=0, and drive ALUop_o, the operands, rd_o, is_branch_o and illegal_o to 0.
REQ-030 SHALL drive instr_ready_o=1 from the first cycle after reset release.
REQ-031 SHALL, when reset is asserted mid-operation, discard all buffered entries with no partial issue.

Structure
REQ-032 SHALL take the ALUop encodings (enum, 6 bits), the opcode constants and the funct3 constants from a shared package, alu_pkg.
REQ-033 SHALL place the combinational decode in one sub-module, alu_op_decode (instr, pc, rs1, rs2 -> entry struct), with the FIFO in the top.

Verification
REQ-034 SHALL verify: ADDI x5,x1,-1 with rs1=0x10 -> next cycle ALUop_o=1, A=0x10, B=0xFFFFFFFF, rd_o=5.
REQ-035 SHALL verify: SUB (instr[30]=1, funct3=000), rs1=7, rs2=3 -> ALUop_o=10, A=7, B=3, is_branch_o=0.
REQ-036 SHALL verify: BGEU, pc=0x100 -> ALUop_o=16, is_branch_o=1, rd_o=0; JAL at pc=0xFFFFFFFC -> A=0x00000000, ALUop_o=17.
REQ-037 SHALL verify: issue_ready_i=0 with 3 pushes at DEPTH=2 -> instr_ready_o=0 after 2, outputs stable; then issue_ready_i=1 with the third held -> push+pop together and in-order drain.
REQ-038 SHALL verify: opcode 0110111 (LUI) -> ALUop_o=0, illegal_o=1, entry issued.
REQ-039 SHALL verify: rst_ni low with 2 entries buffered -> issue_valid_o=0 immediately, outputs 0, no stale entry after release.
